alu_uart_ctrl: RTL and testbench
================================

Name: alu_uart_ctrl

Overview:
Sequencer between the UART receiver/transmitter and the combinational ALU.
- Collects three bytes from UART RX, in order: operand A, operand B, opcode.
- Drives the ALU operand and opcode inputs from internal registers.
- Captures the ALU result and launches one UART TX transfer with it.
- Sits at top level: uart_rx -> alu_uart_ctrl -> alu, and alu -> alu_uart_ctrl -> uart_tx.

Parameters:
NB_DATA, 8, width of operands, result, RX and TX bytes.
NB_OP, 6, ALU opcode width; taken from the LSBs of the opcode byte (NB_OP <= NB_DATA).

Ports:
i_clk  in  1  system clock; all logic on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_rx_data  in  NB_DATA  received byte; valid only when i_rx_done=1.
i_rx_done  in  1  one-cycle pulse, new byte on i_rx_data.
i_tx_done  in  1  one-cycle pulse, UART TX finished its frame.
i_alu_result  in  NB_DATA  ALU combinational result.
o_alu_A  out  NB_DATA  registered operand A to ALU.
o_alu_B  out  NB_DATA  registered operand B to ALU.
o_alu_OP  out  NB_OP  registered opcode to ALU.
o_tx_data  out  NB_DATA  registered byte to UART TX; stable from o_tx_start until i_tx_done.
o_tx_start  out  1  one-cycle pulse requesting a TX transfer.
o_busy  out  1  high in LOAD, SEND and WAIT_TX states.
o_rx_drop  out  1  one-cycle pulse when an RX byte arrives in LOAD, SEND or WAIT_TX and is discarded.

Behaviour:
- All outputs are registered. The FSM is Moore, except o_rx_drop, which is a registered pulse one cycle after the dropped i_rx_done.
- Reset (i_reset=1 at a clock edge):
  - state <= WAIT_A.
  - o_alu_A, o_alu_B, o_alu_OP, o_tx_data <= 0.
  - o_tx_start, o_busy, o_rx_drop <= 0.
  - Reset overrides every other input, including in mid-sequence; a partially collected command is discarded and no TX is issued.
- States: WAIT_A, WAIT_B, WAIT_OP, LOAD, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_alu_A <= i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done, o_alu_B <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_alu_OP <= i_rx_data[NB_OP-1:0], go to LOAD. Upper byte bits are ignored.
- LOAD: unconditional, one cycle, lets the ALU settle on the new registers. At the exit edge: o_tx_data <= i_alu_result, o_tx_start <= 1, go to SEND.
- SEND: o_tx_start=1 for exactly this one cycle; next edge go to WAIT_TX with o_tx_start <= 0.
- WAIT_TX: on i_tx_done go to WAIT_A.
- Latency: i_rx_done of the opcode byte at cycle N gives o_tx_start=1 during cycle N+2.
- Operand and opcode registers hold their values until overwritten, so the ALU output stays observable after TX.
- i_rx_done in LOAD/SEND/WAIT_TX: byte discarded, registers unchanged, o_rx_drop pulses.
- i_tx_done outside WAIT_TX: ignored.
- i_tx_done and i_rx_done in the same cycle in WAIT_TX: go to WAIT_A, the RX byte is dropped (o_rx_drop pulses).
- Arithmetic: none in this block. Result width is NB_DATA and any ALU carry is lost.
- Undefined opcodes are forwarded unchanged; the ALU default (ADD) applies.
- No timeout: the FSM waits indefinitely in WAIT_A/B/OP/WAIT_TX.

Decomposition:
- Shared package/header alu_defs holds:
  - ALU opcode localparams (ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SRA 0x03, SRL 0x02, NOR 0x27).
  - NB_DATA and NB_OP defaults.
  - Controller state encoding (3-bit, WAIT_A=0 ... WAIT_TX=5).
- The ALU and the bench both take opcodes from this package.
- No sub-module: single FSM plus registers. The ALU itself stays external.

Test Plan:
1. RX 0x05, 0x03, 0x20 -> o_alu_A=0x05, o_alu_B=0x03, o_alu_OP=0x20; o_tx_start pulses 2 cycles after the third i_rx_done with o_tx_data=0x08; o_busy=1 until i_tx_done.
2. RX 0x03, 0x05, 0x22 -> o_tx_data=0xFE. RX 0x80, 0x00, 0x03 (SRA) -> o_tx_data=0xC0. RX 0x80, 0x00, 0x02 (SRL) -> o_tx_data=0x40.
3. RX 0x0F, 0xF0, 0xFF -> o_alu_OP=0x3F (upper bits masked); ALU default gives o_tx_data=0xFF.
4. In WAIT_TX, pulse i_rx_done with 0xAA -> o_rx_drop pulses once, no register change. After i_tx_done, next RX 0x01, 0x01, 0x20 -> o_tx_data=0x02.
5. Reset after A and B are received (state WAIT_OP) -> all outputs 0, state WAIT_A. Next RX 0x20 is captured as operand A, not as opcode.
6. i_tx_done pulse while in WAIT_A -> no state change, no o_tx_start. Back-to-back commands (rx_done every cycle) -> each full command yields exactly one o_tx_start.

Source files
------------

// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - ALU opcodes, default widths and controller state encoding
package alu_defs;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        LOAD    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/alu_uart_ctrl.sv
// rtl/alu_uart_ctrl.sv - sequencer collecting A, B, opcode from UART RX and sending the ALU result on UART TX
module alu_uart_ctrl
    import alu_defs::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_A,
    output logic [NB_DATA-1:0] o_alu_B,
    output logic [NB_OP-1:0]   o_alu_OP,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_rx_drop
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic        busy_now;
    logic        busy_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_A:  if (i_rx_done) state_next = WAIT_B;
            WAIT_B:  if (i_rx_done) state_next = WAIT_OP;
            WAIT_OP: if (i_rx_done) state_next = LOAD;
            LOAD:    state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: if (i_tx_done) state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    always_comb begin
        busy_now  = (state == LOAD) || (state == SEND) || (state == WAIT_TX);
        busy_next = (state_next == LOAD) || (state_next == SEND) || (state_next == WAIT_TX);
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_alu_A    <= '0;
            o_alu_B    <= '0;
            o_alu_OP   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_rx_drop  <= 1'b0;
        end else begin
            o_tx_start <= (state == LOAD);
            o_busy     <= busy_next;
            o_rx_drop  <= i_rx_done && busy_now;
            if (state == WAIT_A && i_rx_done) begin
                o_alu_A <= i_rx_data;
            end
            if (state == WAIT_B && i_rx_done) begin
                o_alu_B <= i_rx_data;
            end
            if (state == WAIT_OP && i_rx_done) begin
                o_alu_OP <= i_rx_data[NB_OP-1:0];
            end
            // The ALU has had the whole LOAD cycle to settle on the new operands.
            if (state == LOAD) begin
                o_tx_data <= i_alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb/tb_alu_uart_ctrl.sv - randomized scoreboard bench for alu_uart_ctrl
module tb_alu_uart_ctrl;
    import alu_defs::*;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_done = 1'b0;
    logic       i_tx_done = 1'b0;
    logic [7:0] i_alu_result;
    logic [7:0] o_alu_A;
    logic [7:0] o_alu_B;
    logic [5:0] o_alu_OP;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_rx_drop;

    alu_uart_ctrl dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .i_tx_done    (i_tx_done),
        .i_alu_result (i_alu_result),
        .o_alu_A      (o_alu_A),
        .o_alu_B      (o_alu_B),
        .o_alu_OP     (o_alu_OP),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy),
        .o_rx_drop    (o_rx_drop)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return {a[7], a[7:1]};
            OP_SRL:  return {1'b0, a[7:1]};
            default: return a + b;
        endcase
    endfunction

    // External combinational ALU
    assign i_alu_result = alu_ref(o_alu_A, o_alu_B, o_alu_OP);

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
    } exp_t;

    exp_t tx_q[$];
    exp_t drop_q[$];
    bit   exp_busy[int];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int         nbytes = 0;
    bit         mbusy = 1'b0;
    int         op_edge = 0;
    logic [7:0] ma = 8'h00;
    logic [7:0] mb = 8'h00;
    logic [5:0] mop = 6'h00;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs and advance the transaction-level model for the edge that samples them.
    task automatic step(input bit rst, input bit rx, input logic [7:0] d, input bit tx);
        int   e;
        exp_t x;
        @(negedge i_clk);
        i_reset   = rst;
        i_rx_done = rx;
        i_rx_data = d;
        i_tx_done = tx;
        e = cyc + 1;
        if (rst) begin
            nbytes = 0;
            mbusy  = 1'b0;
            ma = 8'h00; mb = 8'h00; mop = 6'h00;
        end else if (mbusy) begin
            if (rx) begin
                x.cyc = e; x.a = ma; x.b = mb; x.op = mop; x.res = 8'h00;
                drop_q.push_back(x);
            end
            if (tx && e >= op_edge + 3) mbusy = 1'b0;
        end else if (rx) begin
            if (nbytes == 0) ma = d;
            else if (nbytes == 1) mb = d;
            else begin
                mop = d[5:0];
                x.cyc = e + 1; x.a = ma; x.b = mb; x.op = mop; x.res = alu_ref(ma, mb, mop);
                tx_q.push_back(x);
                mbusy = 1'b1;
                op_edge = e;
            end
            nbytes = (nbytes + 1) % 3;
        end
        exp_busy[e] = mbusy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic tx_done();
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic check_zero();
        chk("rst_alu_A", o_alu_A, 0);
        chk("rst_alu_B", o_alu_B, 0);
        chk("rst_alu_OP", o_alu_OP, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_tx_start", o_tx_start, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_rx_drop", o_rx_drop, 0);
    endtask

    always @(negedge i_clk) begin
        exp_t x;
        if (exp_busy.exists(cyc)) chk("busy", o_busy, exp_busy[cyc]);
        while (tx_q.size() > 0 && tx_q[0].cyc < cyc) begin
            void'(tx_q.pop_front());
            chk("tx_start_seen", 0, 1);
        end
        while (drop_q.size() > 0 && drop_q[0].cyc < cyc) begin
            void'(drop_q.pop_front());
            chk("rx_drop_seen", 0, 1);
        end
        if (o_tx_start) begin
            if (tx_q.size() > 0 && tx_q[0].cyc == cyc) begin
                x = tx_q.pop_front();
                chk("tx_data", o_tx_data, x.res);
                chk("tx_alu_A", o_alu_A, x.a);
                chk("tx_alu_B", o_alu_B, x.b);
                chk("tx_alu_OP", o_alu_OP, x.op);
            end else begin
                chk("tx_start_expected", 1, 0);
            end
        end
        if (o_rx_drop) begin
            if (drop_q.size() > 0 && drop_q[0].cyc == cyc) begin
                x = drop_q.pop_front();
                chk("drop_alu_A", o_alu_A, x.a);
                chk("drop_alu_B", o_alu_B, x.b);
                chk("drop_alu_OP", o_alu_OP, x.op);
            end else begin
                chk("rx_drop_expected", 1, 0);
            end
        end
    end

    initial begin
        logic [5:0] ops [8];
        logic [7:0] d;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle(1);
        check_zero();

        send(8'h05); send(8'h03); send(8'h20); idle(4); tx_done(); idle(1);
        send(8'h03); send(8'h05); send(8'h22); idle(3); tx_done();
        send(8'h80); idle(2); send(8'h00); send(8'h03); idle(5); tx_done();
        send(8'h80); send(8'h00); send(8'h02); idle(3); tx_done();
        send(8'h0F); send(8'hF0); send(8'hFF); idle(3); tx_done();

        send(8'h01); send(8'h02); send(8'h20); idle(3);
        send(8'hAA); idle(2); tx_done();
        send(8'h01); send(8'h01); send(8'h20); idle(3);
        step(1'b0, 1'b1, 8'h55, 1'b1);
        idle(2);

        send(8'h11); send(8'h22);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle(1);
        check_zero();
        send(8'h20); idle(1);
        chk("reset_then_A", o_alu_A, 8'h20);
        send(8'h01); send(8'h20); idle(3); tx_done();

        tx_done(); idle(3);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'(i + 1), 1'b1);
        for (int i = 0; i < 12; i++) send(8'(i * 7));
        idle(3); tx_done(); idle(2);

        for (int i = 0; i < 3000; i++) begin
            d = ($urandom_range(0, 1) == 0) ? {2'b00, ops[$urandom_range(0, 7)]} : 8'($urandom);
            step(1'b0, $urandom_range(0, 1) == 1, d, $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 8; i++) begin
            idle(3);
            tx_done();
        end
        idle(4);

        chk("tx_queue_empty", tx_q.size(), 0);
        chk("drop_queue_empty", drop_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
